// File: rtl/flow_pkg.sv
// Shared definitions for the 8-lane flow counters: lane/tag widths and
// the popcount/thermometer helpers used by both the write and read sides.
package flow_pkg;

   localparam int LANES = 8;
   localparam int TAG_W = 8;

   function automatic logic [3:0] popcnt8(input logic [0:LANES-1] m);
      logic [3:0] s;
      s = '0;
      for (int i = 0; i < LANES; i++) begin
         s = s + {3'b000, m[i]};
      end
      return s;
   endfunction

   // Bits 0..n-1 set, bit 0 first; n saturates at LANES.
   function automatic logic [0:LANES-1] therm8(input logic [3:0] n);
      logic [0:LANES-1] t;
      t = '0;
      for (int i = 0; i < LANES; i++) begin
         t[i] = (4'(i) < n);
      end
      return t;
   endfunction

endpackage

// File: rtl/flow_drain8_if.sv
// Producer/consumer handshake bundle for the read-side flow counter.
// slave is the counter; master is whoever drives arrivals, releases and flushes.
interface flow_drain8_if
   import flow_pkg::*;
   #(parameter int CAPACITY = 64);

   localparam int CW = $clog2(CAPACITY + 1);

   logic             inEn;
   logic [0:LANES-1] inMask;
   logic             inReady;
   logic             outReady;
   logic             outValid;
   logic [0:LANES-1] outMask;
   logic [TAG_W-1:0] readTag;
   logic             flushEn;
   logic [TAG_W-1:0] flushTag;
   logic [CW-1:0]    count;
   logic             overflowErr;

   modport slave (
      input  inEn, inMask, outReady, flushEn, flushTag,
      output inReady, outValid, outMask, readTag, count, overflowErr
   );

   modport master (
      output inEn, inMask, outReady, flushEn, flushTag,
      input  inReady, outValid, outMask, readTag, count, overflowErr
   );

endinterface

// File: rtl/flow_drain8_popcount8.sv
// 8-lane popcount; one instance counts arrivals, the other releases.
module popcount8
   import flow_pkg::*;
(
   input  logic [0:LANES-1] mask,
   output logic [3:0]       pop
);

   assign pop = popcnt8(mask);

endmodule

// File: rtl/flow_drain8.sv
// Read-side occupancy tracker for an in-order buffer: accepts 8-lane arrival
// groups, offers thermometer release masks, and advances the read tag.
module flow_drain8
   import flow_pkg::*;
   #(parameter int CAPACITY = 64)
(
   input  logic clk,
   input  logic resetN,
   flow_drain8_if.slave bus
);

   localparam int CW = $clog2(CAPACITY + 1);
   localparam logic [CW-1:0] OPEN_MARK = CW'(CAPACITY - LANES);

   logic [CW-1:0]    countQ;
   logic [TAG_W-1:0] tagQ;
   logic             errQ;

   logic [3:0]       popIn;
   logic [3:0]       popOut;
   logic [3:0]       nOut;
   logic             accepted;
   logic             taken;
   logic [CW:0]      addIn;
   logic [CW:0]      subOut;
   logic [CW:0]      countNext;

   popcount8 u_popIn  (.mask(bus.inMask),  .pop(popIn));
   popcount8 u_popOut (.mask(bus.outMask), .pop(popOut));

   // All outputs decode from registered state only.
   assign nOut            = (countQ >= CW'(LANES)) ? 4'd8 : countQ[3:0];
   assign bus.outMask     = therm8(nOut);
   assign bus.outValid    = (countQ != '0);
   assign bus.inReady     = (countQ <= OPEN_MARK);
   assign bus.count       = countQ;
   assign bus.readTag     = tagQ;
   assign bus.overflowErr = errQ;

   assign accepted  = bus.inEn & bus.inReady;
   assign taken     = bus.outReady & bus.outValid;
   assign addIn     = accepted ? (CW+1)'(popIn)  : '0;
   assign subOut    = taken    ? (CW+1)'(popOut) : '0;
   assign countNext = {1'b0, countQ} + addIn - subOut;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         countQ <= '0;
         tagQ   <= '0;
         errQ   <= 1'b0;
      end else if (bus.flushEn) begin
         countQ <= '0;
         tagQ   <= bus.flushTag;
      end else begin
         countQ <= countNext[CW-1:0];
         tagQ   <= tagQ + {{(TAG_W-4){1'b0}}, (taken ? popOut : 4'd0)};
         if (bus.inEn && !bus.inReady && (popIn != 4'd0)) begin
            errQ <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_flow_drain8.sv
// Directed bench for flow_drain8 with CAPACITY = 64.
module tb_flow_drain8;
   import flow_pkg::*;

   logic clk;
   logic resetN;
   int   tests;
   int   failed;

   flow_drain8_if #(.CAPACITY(64)) bus ();

   flow_drain8 #(.CAPACITY(64)) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic en, input logic [7:0] m, input logic rdy);
      bus.inEn     = en;
      bus.inMask   = m;
      bus.outReady = rdy;
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      resetN = 1'b0;
      bus.flushEn  = 1'b0;
      bus.flushTag = 8'h00;
      drive(1'b0, 8'h00, 1'b0);
      step();
      step();
      resetN = 1'b1;

      chk("rst_count",   32'(bus.count),       32'd0);
      chk("rst_tag",     32'(bus.readTag),     32'd0);
      chk("rst_err",     32'(bus.overflowErr), 32'd0);
      chk("rst_valid",   32'(bus.outValid),    32'd0);
      chk("rst_mask",    32'(bus.outMask),     32'h00);
      chk("rst_inready", 32'(bus.inReady),     32'd1);

      // Arrival of 3; no bypass to outValid in the same cycle.
      drive(1'b1, 8'b1011_0000, 1'b0);
      #1;
      chk("nobypass_valid", 32'(bus.outValid), 32'd0);
      step();
      drive(1'b0, 8'h00, 1'b0);
      chk("arr3_count", 32'(bus.count),    32'd3);
      chk("arr3_mask",  32'(bus.outMask),  32'hE0);
      chk("arr3_valid", 32'(bus.outValid), 32'd1);
      drive(1'b0, 8'h00, 1'b1);
      step();
      drive(1'b0, 8'h00, 1'b0);
      chk("rel3_count", 32'(bus.count),   32'd0);
      chk("rel3_tag",   32'(bus.readTag), 32'd3);

      // Fill to the full boundary.
      drive(1'b1, 8'hFF, 1'b0);
      for (int i = 0; i < 7; i++) step();
      chk("fill56_count",   32'(bus.count),   32'd56);
      chk("fill56_inready", 32'(bus.inReady), 32'd1);
      chk("fill56_mask",    32'(bus.outMask), 32'hFF);
      drive(1'b1, 8'b0001_0000, 1'b0);
      step();
      chk("fill57_count",   32'(bus.count),       32'd57);
      chk("fill57_inready", 32'(bus.inReady),     32'd0);
      chk("fill57_err",     32'(bus.overflowErr), 32'd0);
      drive(1'b1, 8'b1100_0000, 1'b0);
      step();
      drive(1'b0, 8'h00, 1'b0);
      chk("reject_count", 32'(bus.count),       32'd57);
      chk("reject_err",   32'(bus.overflowErr), 32'd1);
      step();
      chk("sticky_err", 32'(bus.overflowErr), 32'd1);

      // Release at the boundary does not reopen inReady until next cycle.
      drive(1'b0, 8'h00, 1'b1);
      #1;
      chk("rel_same_inready", 32'(bus.inReady), 32'd0);
      step();
      drive(1'b0, 8'h00, 1'b0);
      chk("rel49_count",   32'(bus.count),   32'd49);
      chk("rel49_tag",     32'(bus.readTag), 32'd11);
      chk("rel49_inready", 32'(bus.inReady), 32'd1);

      // Flush to preload a tag near wrap; overflowErr survives the flush.
      bus.flushEn  = 1'b1;
      bus.flushTag = 8'd232;
      step();
      bus.flushEn  = 1'b0;
      chk("flush232_count", 32'(bus.count),       32'd0);
      chk("flush232_tag",   32'(bus.readTag),     32'd232);
      chk("flush232_err",   32'(bus.overflowErr), 32'd1);

      drive(1'b1, 8'hFF, 1'b0);
      step();
      step();
      drive(1'b1, 8'b1010_1010, 1'b0);
      step();
      chk("pre_stream_count", 32'(bus.count), 32'd20);

      // Steady streaming: 8 in, 8 out per cycle.
      drive(1'b1, 8'hFF, 1'b1);
      step();
      chk("stream1_count", 32'(bus.count),   32'd20);
      chk("stream1_tag",   32'(bus.readTag), 32'd240);
      step();
      chk("stream2_tag",   32'(bus.readTag), 32'd248);
      step();
      chk("stream3_count", 32'(bus.count),   32'd20);
      chk("stream3_tag",   32'(bus.readTag), 32'd0);
      step();
      chk("stream4_tag",   32'(bus.readTag), 32'd8);

      drive(1'b1, 8'hFF, 1'b0);
      step();
      drive(1'b1, 8'b1000_0001, 1'b0);
      step();
      chk("pre_flush_count", 32'(bus.count), 32'd30);

      // Flush with live handshakes: both are void.
      drive(1'b1, 8'hFF, 1'b1);
      bus.flushEn  = 1'b1;
      bus.flushTag = 8'h7F;
      step();
      bus.flushEn = 1'b0;
      drive(1'b0, 8'h00, 1'b0);
      chk("flush7f_count", 32'(bus.count),       32'd0);
      chk("flush7f_tag",   32'(bus.readTag),     32'h7F);
      chk("flush7f_valid", 32'(bus.outValid),    32'd0);
      chk("flush7f_err",   32'(bus.overflowErr), 32'd1);

      // Simultaneous arrival of 4 and release of 5 at count 5.
      drive(1'b1, 8'b1111_1000, 1'b0);
      step();
      chk("cnt5_count", 32'(bus.count),   32'd5);
      chk("cnt5_mask",  32'(bus.outMask), 32'hF8);
      drive(1'b1, 8'b0101_0101, 1'b1);
      step();
      drive(1'b0, 8'h00, 1'b0);
      chk("simul_count", 32'(bus.count),   32'd4);
      chk("simul_tag",   32'(bus.readTag), 32'h84);
      chk("simul_mask",  32'(bus.outMask), 32'hF0);

      // Mid-stream reset clears everything including overflowErr.
      drive(1'b1, 8'hFF, 1'b1);
      resetN = 1'b0;
      step();
      resetN = 1'b1;
      drive(1'b0, 8'h00, 1'b0);
      chk("mrst_count",   32'(bus.count),       32'd0);
      chk("mrst_tag",     32'(bus.readTag),     32'd0);
      chk("mrst_err",     32'(bus.overflowErr), 32'd0);
      chk("mrst_valid",   32'(bus.outValid),    32'd0);
      chk("mrst_mask",    32'(bus.outMask),     32'h00);
      chk("mrst_inready", 32'(bus.inReady),     32'd1);

      // outReady while empty and a zero-lane arrival are both no-ops.
      drive(1'b1, 8'h00, 1'b1);
      step();
      drive(1'b0, 8'h00, 1'b0);
      chk("noop_count", 32'(bus.count),   32'd0);
      chk("noop_tag",   32'(bus.readTag), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
